tile_writeback: RTL
===================

Name: tile_writeback

Overview:
- Downstream neighbour of the pixel shader. Flushes one completed tileDim x tileDim colour tile from the ping-pong tile buffers (cBufferTile0/1) into the 16-bit asynchronous SRAM framebuffer.
- Issues one SRAM write per on-screen pixel with a setup/strobe cycle pair.
- Signals completion so the scheduler can recycle that buffer for the next rasterTileID.

Parameters:
- tileDim, 8, tile edge length in pixels; same value as the pixel shader.
- screenWidth, 640, framebuffer width in pixels.
- screenHeight, 480, framebuffer height in pixels.
- fbBase, 0, 20-bit SRAM word address of pixel (0,0).

Ports:
- BOARD_CLK  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to flush a tile; sampled only in IDLE.
- tileID  in  1  selects the source buffer: 0 = cBufferTile0, 1 = cBufferTile1.
- cBufferTile0  in  16 x [tileDim][tileDim]  tile colour buffer 0, indexed [x][y], RGB565.
- cBufferTile1  in  16 x [tileDim][tileDim]  tile colour buffer 1, indexed [x][y].
- tileOffsetX  in  10  screen x of tile pixel (0,0).
- tileOffsetY  in  10  screen y of tile pixel (0,0).
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.
- SRAM_ADDR  out  20  word address.
- SRAM_DQ_OUT  out  16  write data.
- SRAM_DQ_OE  out  1  drives the top-level DQ tristate.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_CE_N  out  1  chip enable, active low.
- SRAM_OE_N  out  1  output enable, active low; held high by this block.
- SRAM_UB_N  out  1  upper byte enable, active low.
- SRAM_LB_N  out  1  lower byte enable, active low.

Behaviour:
- Reset (async, immediate), with all outputs registered:
  - State IDLE; tx = ty = 0.
  - busy = 0, done = 0.
  - SRAM_ADDR = 0, SRAM_DQ_OUT = 0, SRAM_DQ_OE = 0.
  - SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N all = 1.
  - Reset mid-flush abandons the tile; WE_N goes high asynchronously; there is no partial-write recovery.
- States: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - If start = 1, latch tileID, tileOffsetX and tileOffsetY; set tx = ty = 0; go to SETUP.
  - Otherwise stay.
  - Latched copies are used for the whole flush; input changes during busy are ignored.
- Pixel coordinates:
  - sx = offX + tx, sy = offY + ty, both computed at 11 bits (no 10-bit wrap).
  - On-screen means sx < screenWidth and sy < screenHeight.
  - Address = fbBase + sy*screenWidth + sx, computed at 20 bits, truncating.
- SETUP (one cycle per pixel):
  - If on-screen: register SRAM_ADDR and SRAM_DQ_OUT = selected buffer[tx][ty]; DQ_OE = 1; WE_N = 1; go to STROBE.
  - If off-screen: no write; advance the pixel and stay in SETUP, or go to DONE if this was the last pixel. This costs one cycle.
- STROBE:
  - WE_N = 0.
  - ADDR and DQ_OUT are held unchanged from SETUP.
  - Advance the pixel; go to SETUP, or to DONE after the last pixel.
  - WE_N returns to 1 on the following cycle.
- Pixel advance order is raster, x fastest:
  - tx+1; at tileDim, tx = 0 and ty+1.
  - Last pixel is tx = ty = tileDim-1.
- DONE:
  - done = 1, busy = 1, DQ_OE = 0, WE_N = 1; go to IDLE.
- SRAM control signals:
  - CE_N, UB_N and LB_N are 0 in SETUP and STROBE, 1 otherwise.
  - OE_N is always 1.
- busy is 1 in SETUP, STROBE and DONE.
- Latency:
  - Start is accepted on edge 0.
  - A fully on-screen tile takes 2*tileDim² cycles of SETUP/STROBE, so done is high in cycle 2*tileDim²+1 (129 at default).
  - In general, busy duration = 2*(on-screen pixels) + (off-screen pixels) + 1.
- start during busy, including the DONE cycle, is ignored and not queued. A new start is accepted the cycle after DONE.
- Buffer contents must be stable while busy; the upstream scheduler guarantees the shader writes only the other tileID.

Test Plan:
- Full tile, tileID=0, offset (0,0), buf0[x][y] = {y,x} pattern:
  - 64 WE_N low pulses, each 1 cycle, separated by 1 high cycle.
  - Addresses in order 0,1,…,7,640,…,4487, with data matching buf0.
  - done high in cycle 129; busy low in cycle 130.
- tileID=1, offset (632,472):
  - First write addr 302712 = buf1[0][0]; last write addr 307199 (0x4AFFF) = buf1[7][7].
  - buf0 is never read.
- screenWidth=636, offset (632,0):
  - Only tx 0..3 written: 32 strobes; addresses 632..635 + 636*ty.
  - done in cycle 97.
- start pulsed at cycles 10 and 129 during a flush, and tileOffsetX changed mid-flush:
  - No restart; addresses unaffected.
  - start at cycle 130 begins a new flush.
- reset asserted mid-STROBE at pixel 20:
  - WE_N = 1, CE_N = 1, busy = 0 immediately.
  - No done pulse.
  - A subsequent start writes from pixel (0,0).

Source files
------------

// File: rtl/tile_writeback.sv
// Flushes one tileDim x tileDim RGB565 tile from the selected ping-pong buffer
// into an async SRAM framebuffer, one setup/strobe write per on-screen pixel.
module tile_writeback #(
  parameter int          tileDim      = 8,
  parameter int          screenWidth  = 640,
  parameter int          screenHeight = 480,
  parameter logic [19:0] fbBase       = 20'd0
) (
  input  logic        BOARD_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        tileID,
  input  logic [15:0] cBufferTile0 [tileDim][tileDim],
  input  logic [15:0] cBufferTile1 [tileDim][tileDim],
  input  logic [9:0]  tileOffsetX,
  input  logic [9:0]  tileOffsetY,
  output logic        busy,
  output logic        done,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int              TW   = (tileDim > 1) ? $clog2(tileDim) : 1;
  localparam logic [TW-1:0]   LAST = TW'(tileDim - 1);
  localparam logic [11:0]     SW   = 12'(screenWidth);
  localparam logic [11:0]     SH   = 12'(screenHeight);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tx, r_ty;
  logic          r_id;
  logic [9:0]    r_off_x, r_off_y;
  logic          r_on;
  logic          r_busy, r_done, r_dq_oe, r_we_n, r_ce_n;
  logic [19:0]   r_addr;
  logic [15:0]   r_dq;

  logic          w_idle, w_last;
  logic [TW-1:0] w_adv_tx, w_adv_ty, w_ev_tx, w_ev_ty;
  logic [9:0]    w_ev_offx, w_ev_offy;
  logic          w_ev_id;
  logic [10:0]   w_sx, w_sy;
  logic          w_on;
  logic [19:0]   w_addr;
  logic [15:0]   w_data;
  logic          w_next_pix, w_to_done;
  logic [15:0]   w_sel [tileDim][tileDim];

  // Everything below evaluates the pixel the FSM is about to enter, so the
  // registered SRAM outputs line up with the state they belong to.
  assign w_idle   = (r_state == IDLE);
  assign w_last   = (r_tx == LAST) && (r_ty == LAST);
  assign w_adv_tx = (r_tx == LAST) ? '0 : r_tx + TW'(1);
  assign w_adv_ty = (r_tx == LAST) ? r_ty + TW'(1) : r_ty;

  assign w_ev_tx   = w_idle ? '0 : w_adv_tx;
  assign w_ev_ty   = w_idle ? '0 : w_adv_ty;
  assign w_ev_offx = w_idle ? tileOffsetX : r_off_x;
  assign w_ev_offy = w_idle ? tileOffsetY : r_off_y;
  assign w_ev_id   = w_idle ? tileID : r_id;

  assign w_sx   = 11'(w_ev_offx) + 11'(w_ev_tx);
  assign w_sy   = 11'(w_ev_offy) + 11'(w_ev_ty);
  assign w_on   = ({1'b0, w_sx} < SW) && ({1'b0, w_sy} < SH);
  assign w_addr = fbBase + 20'(w_sy) * 20'(screenWidth) + 20'(w_sx);

  genvar gi, gj;
  generate
    for (gi = 0; gi < tileDim; gi++) begin : g_col
      for (gj = 0; gj < tileDim; gj++) begin : g_row
        assign w_sel[gi][gj] = w_ev_id ? cBufferTile1[gi][gj] : cBufferTile0[gi][gj];
      end
    end
  endgenerate

  assign w_data = w_sel[w_ev_tx][w_ev_ty];

  assign w_next_pix = (w_idle && start)
                   || (r_state == SETUP && !r_on && !w_last)
                   || (r_state == STROBE && !w_last);
  assign w_to_done  = (r_state == SETUP && !r_on && w_last)
                   || (r_state == STROBE && w_last);

  always_ff @(posedge BOARD_CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_ty    <= '0;
      r_id    <= 1'b0;
      r_off_x <= '0;
      r_off_y <= '0;
      r_on    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_dq    <= '0;
      r_dq_oe <= 1'b0;
      r_we_n  <= 1'b1;
      r_ce_n  <= 1'b1;
    end else begin
      if (w_idle && start) begin
        r_id    <= tileID;
        r_off_x <= tileOffsetX;
        r_off_y <= tileOffsetY;
      end
      if (w_next_pix) begin
        r_state <= SETUP;
        r_tx    <= w_ev_tx;
        r_ty    <= w_ev_ty;
        r_on    <= w_on;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_ce_n  <= 1'b0;
        r_we_n  <= 1'b1;
        r_dq_oe <= w_on;
        if (w_on) begin
          r_addr <= w_addr;
          r_dq   <= w_data;
        end
      end else if (w_to_done) begin
        r_state <= DONE;
        r_busy  <= 1'b1;
        r_done  <= 1'b1;
        r_ce_n  <= 1'b1;
        r_we_n  <= 1'b1;
        r_dq_oe <= 1'b0;
      end else begin
        case (r_state)
          SETUP: begin
            // on-screen pixel: address and data stay put while WE_N strobes
            r_state <= STROBE;
            r_we_n  <= 1'b0;
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tx    <= '0;
            r_ty    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign SRAM_ADDR   = r_addr;
  assign SRAM_DQ_OUT = r_dq;
  assign SRAM_DQ_OE  = r_dq_oe;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_UB_N   = r_ce_n;
  assign SRAM_LB_N   = r_ce_n;
  assign SRAM_OE_N   = 1'b1;

endmodule
